// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between the instruction-memory bus and the IF stage.
// Issues sequential word fetches and buffers the returned words with their PC in
// a small FIFO. Responses to requests issued before a redirect are counted in
// 'drop' and discarded as they come back, so stale instructions never enter the
// queue.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_PC,
  output logic [31:0] fetch_NPC,
  output logic [31:0] fetch_IR
);

  localparam int          PW        = $clog2(DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW:0] DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  logic [31:0]   req_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] live;
  logic [CW-1:0] drop;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];

  logic [CW:0]   occ_sum;
  logic [CW:0]   out_sum;
  logic          accept;
  logic          push;
  logic          pop;
  logic          resp_drop;

  // Issue gate and handshake qualifiers. count+live bounds the FIFO so a
  // response always has a slot; live+drop bounds what the memory holds.
  always_comb begin
    occ_sum        = {1'b0, count} + {1'b0, live};
    out_sum        = {1'b0, live} + {1'b0, drop};
    imem_req_valid = rst_n && !redirect_valid && (occ_sum < DEPTH_W) && (out_sum < DEPTH_W);
    imem_req_addr  = req_pc;
    accept         = imem_req_valid && imem_req_ready;
    resp_drop      = imem_resp_valid && (drop != '0);
    push           = imem_resp_valid && (drop == '0) && !redirect_valid;
    pop            = fetch_valid && fetch_ready && !redirect_valid;
  end

  // Head of the queue; when empty, show a NOOP and the next PC expected to arrive.
  always_comb begin
    fetch_valid = (count != '0);
    fetch_PC    = fetch_valid ? pc_mem[head] : resp_pc;
    fetch_IR    = fetch_valid ? ir_mem[head] : NOOP_INST;
    fetch_NPC   = fetch_PC + 32'd4;
  end

  // Control state: fetch/response PCs, occupancy, in-flight bookkeeping, pointers.
  // A redirect wins over everything; everything still in flight becomes 'drop',
  // minus the response that lands (and is discarded) in the redirect cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc  <= RESET_PC;
      resp_pc <= RESET_PC;
      count   <= '0;
      live    <= '0;
      drop    <= '0;
      head    <= '0;
      tail    <= '0;
    end else if (redirect_valid) begin
      req_pc  <= redirect_pc;
      resp_pc <= redirect_pc;
      count   <= '0;
      live    <= '0;
      drop    <= drop + live - CW'(imem_resp_valid);
      head    <= '0;
      tail    <= '0;
    end else begin
      if (accept) req_pc <= req_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        tail    <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      live  <= live + CW'(accept) - CW'(push);
      drop  <= drop - CW'(resp_drop);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only observed while count covers them, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail] <= resp_pc;
      ir_mem[tail] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: an in-order variable-latency memory model, a
// table of hand-computed cycle vectors, a mid-stream reset sequence and a
// random run checked against the expected sequential PC stream.
module tb_if_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_PC;
  logic [31:0] fetch_NPC;
  logic [31:0] fetch_IR;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_PC(fetch_PC), .fetch_NPC(fetch_NPC), .fetch_IR(fetch_IR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          rst;
    int          lat;
    bit          rdr;
    logic [31:0] rpc;
    bit          rq;
    bit          fr;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_fv;
    logic [31:0] e_pc;
    string       tag;
  } vec_t;

  mreq_t       memq[$];
  vec_t        tbl[$];
  vec_t        v;
  int          cyc = 0;
  int          last_due = 0;
  int          cur_lat = 1;
  int          total = 0;
  int          bad = 0;
  bit          s_rv, s_fv, s_acc, s_pop;
  logic [31:0] s_addr, s_pc, s_npc, s_ir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  function automatic vec_t mk(input bit rst, input int lat, input bit rdr, input logic [31:0] rpc,
                              input bit rq, input bit fr, input bit e_rv, input logic [31:0] e_addr,
                              input bit e_fv, input logic [31:0] e_pc, input string tag);
    vec_t r;
    r.rst = rst; r.lat = lat; r.rdr = rdr; r.rpc = rpc; r.rq = rq; r.fr = fr;
    r.e_rv = e_rv; r.e_addr = e_addr; r.e_fv = e_fv; r.e_pc = e_pc; r.tag = tag;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, let the memory model
  // advance at the rising edge.
  task automatic step(input bit rdr, input logic [31:0] rpc, input bit rq, input bit fr);
    int due;
    @(negedge clk);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(memq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    redirect_valid = rdr;
    redirect_pc    = rpc;
    imem_req_ready = rq;
    fetch_ready    = fr;
    #1;
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    s_fv   = fetch_valid;
    s_pc   = fetch_PC;
    s_npc  = fetch_NPC;
    s_ir   = fetch_IR;
    s_acc  = s_rv && rq;
    s_pop  = s_fv && fr && !rdr;
    @(posedge clk);
    if (imem_resp_valid) void'(memq.pop_front());
    if (s_acc) begin
      due = cyc + cur_lat;
      if (due <= last_due) due = last_due + 1;
      memq.push_back('{s_addr, due});
      last_due = due;
    end
    cyc++;
  endtask

  // Asynchronous reset between edges; outputs must take reset values at once.
  task automatic apply_reset();
    #3;
    rst_n = 1'b0;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; fetch_ready = 1'b0;
    memq.delete();
    last_due = 0;
    #1;
    chk("reset fetch_valid", fetch_valid, 0);
    chk("reset fetch_IR", fetch_IR, NOOP);
    chk("reset fetch_PC", fetch_PC, 32'h0);
    chk("reset fetch_NPC", fetch_NPC, 32'h4);
    chk("reset imem_req_valid", imem_req_valid, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_pc, exp_req, rpc;
  bit          rdr, after_rdr;
  int          delivered, cycles;

  initial begin
    // rst lat rdr rpc rq fr | req_valid addr fetch_valid pc
    // streaming, latency 1
    tbl.push_back(mk(1,1,0,0,1,1, 1,32'h0,  0,0,     "stream"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h4,  0,0,     "stream"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h8,  1,32'h0, "stream"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'hC,  1,32'h4, "stream"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h10, 1,32'h8, "stream"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h14, 1,32'hC, "stream"));
    // stall fills exactly DEPTH entries, then drains in order
    tbl.push_back(mk(1,1,0,0,1,0, 1,32'h0,  0,0,     "stall"));
    tbl.push_back(mk(0,1,0,0,1,0, 1,32'h4,  0,0,     "stall"));
    tbl.push_back(mk(0,1,0,0,1,0, 1,32'h8,  1,32'h0, "stall"));
    tbl.push_back(mk(0,1,0,0,1,0, 1,32'hC,  1,32'h0, "stall"));
    tbl.push_back(mk(0,1,0,0,1,0, 0,0,      1,32'h0, "stall"));
    tbl.push_back(mk(0,1,0,0,1,0, 0,0,      1,32'h0, "stall"));
    tbl.push_back(mk(0,1,0,0,1,0, 0,0,      1,32'h0, "stall"));
    tbl.push_back(mk(0,1,0,0,1,1, 0,0,      1,32'h0, "stall"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h10, 1,32'h4, "stall"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h14, 1,32'h8, "stall"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h18, 1,32'hC, "stall"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h1C, 1,32'h10,"stall"));
    // latency 3, redirect with three requests outstanding
    tbl.push_back(mk(1,3,0,0,1,1, 1,32'h0,  0,0,     "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h4,  0,0,     "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h8,  0,0,     "flush"));
    tbl.push_back(mk(0,3,1,32'h100,1,1, 0,0, 0,0,    "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h100,0,0,     "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h104,0,0,     "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h108,0,0,     "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h10C,0,0,     "flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 0,0,      1,32'h100,"flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h110,1,32'h104,"flush"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h114,1,32'h108,"flush"));
    // redirect together with a response and a ready consumer
    tbl.push_back(mk(1,1,0,0,1,1, 1,32'h0,  0,0,     "rdr_resp"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h4,  0,0,     "rdr_resp"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h8,  1,32'h0, "rdr_resp"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'hC,  1,32'h4, "rdr_resp"));
    tbl.push_back(mk(0,1,1,32'h200,1,1, 0,0, 1,32'h8,"rdr_resp"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h200,0,0,     "rdr_resp"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h204,0,0,     "rdr_resp"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h208,1,32'h200,"rdr_resp"));
    // PC wrap past 32'hFFFF_FFFC
    tbl.push_back(mk(1,1,1,32'hFFFF_FFF8,1,1, 0,0, 0,0, "wrap"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'hFFFF_FFF8, 0,0, "wrap"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'hFFFF_FFFC, 0,0, "wrap"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h0, 1,32'hFFFF_FFF8, "wrap"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h4, 1,32'hFFFF_FFFC, "wrap"));
    tbl.push_back(mk(0,1,0,0,1,1, 1,32'h8, 1,32'h0, "wrap"));
    // back-to-back redirects, latency 3: last target wins
    tbl.push_back(mk(1,3,0,0,1,1, 1,32'h0,  0,0,     "rdr2"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h4,  0,0,     "rdr2"));
    tbl.push_back(mk(0,3,1,32'h300,1,1, 0,0, 0,0,    "rdr2"));
    tbl.push_back(mk(0,3,1,32'h400,1,1, 0,0, 0,0,    "rdr2"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h400,0,0,     "rdr2"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h404,0,0,     "rdr2"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h408,0,0,     "rdr2"));
    tbl.push_back(mk(0,3,0,0,1,1, 1,32'h40C,0,0,     "rdr2"));
    tbl.push_back(mk(0,3,0,0,1,1, 0,0,      1,32'h400,"rdr2"));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.rst) apply_reset();
      cur_lat = v.lat;
      step(v.rdr, v.rpc, v.rq, v.fr);
      chk($sformatf("%s[%0d] req_valid", v.tag, i), s_rv, v.e_rv);
      if (v.e_rv) chk($sformatf("%s[%0d] req_addr", v.tag, i), s_addr, v.e_addr);
      chk($sformatf("%s[%0d] fetch_valid", v.tag, i), s_fv, v.e_fv);
      if (v.e_fv) begin
        chk($sformatf("%s[%0d] fetch_PC", v.tag, i), s_pc, v.e_pc);
        chk($sformatf("%s[%0d] fetch_NPC", v.tag, i), s_npc, v.e_pc + 32'd4);
        chk($sformatf("%s[%0d] fetch_IR", v.tag, i), s_ir, mem_word(v.e_pc));
      end else begin
        chk($sformatf("%s[%0d] fetch_IR", v.tag, i), s_ir, NOOP);
      end
    end

    // Reset in mid-stream with two entries queued and two requests outstanding.
    apply_reset();
    cur_lat = 2;
    step(0, 0, 1, 0); chk("midrst c0 addr", s_addr, 32'h0);
    step(0, 0, 1, 0); chk("midrst c1 addr", s_addr, 32'h4);
    step(0, 0, 1, 0); chk("midrst c2 addr", s_addr, 32'h8);
    step(0, 0, 1, 0); chk("midrst c3 addr", s_addr, 32'hC);
    chk("midrst c3 fetch_valid", s_fv, 1);
    apply_reset();
    step(0, 0, 1, 1);
    chk("midrst first req_valid", s_rv, 1);
    chk("midrst first req_addr", s_addr, 32'h0);

    // Random traffic with redirects, checked against the sequential PC stream.
    apply_reset();
    exp_pc = 32'h0; exp_req = 32'h0; delivered = 0; cycles = 0; after_rdr = 0;
    while (delivered < 1000 && cycles < 40000) begin
      cur_lat = $urandom_range(1, 5);
      rdr = ($urandom_range(0, 49) == 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      step(rdr, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
      if (after_rdr) chk("rnd fetch_valid after redirect", s_fv, 0);
      if (rdr) chk("rnd req during redirect", s_rv, 0);
      if (s_acc) begin
        chk("rnd req_addr", s_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (s_pop) begin
        chk("rnd fetch_PC", s_pc, exp_pc);
        chk("rnd fetch_NPC", s_npc, exp_pc + 32'd4);
        chk("rnd fetch_IR", s_ir, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (rdr) begin
        exp_pc  = rpc;
        exp_req = rpc;
      end
      chk("rnd outstanding within depth", (memq.size() <= DEPTH), 1);
      after_rdr = rdr;
      cycles++;
    end
    if (delivered < 1000) begin
      total++;
      bad++;
      $display("FAIL rnd timeout: delivered %0d want 1000", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
